// File: rtl/gps_track_pkg.sv
// Shared types and helpers for the tracking correlator channel.
package gps_track_pkg;

    // Channel control FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StIntegrate
    } corr_state_e;

    // Conventional tap roles.
    localparam int unsigned TAP_E = 0;
    localparam int unsigned TAP_P = 1;
    localparam int unsigned TAP_L = 2;

    // Add two sign-extended values and clamp to the symmetric range
    // +/-(2^(acc_w-1)-1). Operands are always far inside 64 bits, so the
    // raw sum cannot overflow.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned acc_w);
        logic signed [63:0] lim;
        logic signed [63:0] sum;
        logic signed [63:0] res;
        lim = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        sum = a + b;
        if (sum > lim) begin
            res = lim;
        end else if (sum < -lim) begin
            res = -lim;
        end else begin
            res = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/corr_acc_lane.sv
// One tap's I/Q accumulator pair: clear, seed with a product, or add a
// product, always saturating.
module corr_acc_lane
    import gps_track_pkg::*;
#(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned ACC_W = 24
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clear,
    input  logic                    seed,
    input  logic                    add,
    input  logic signed [IN_W-1:0]  sample,
    input  logic                    neg_i,
    input  logic                    neg_q,
    output logic signed [ACC_W-1:0] acc_i,
    output logic signed [ACC_W-1:0] acc_q
);

    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic signed [63:0]      ext, prod_i, prod_q, base_i, base_q, sum_i, sum_q;

    // Form the signed products and the next accumulator values.
    always_comb begin
        ext    = 64'(sample);
        prod_i = neg_i ? -ext : ext;
        prod_q = neg_q ? -ext : ext;
        // A seed restarts the sum from zero with this sample's product.
        base_i = seed ? 64'sd0 : 64'(acc_i_q);
        base_q = seed ? 64'sd0 : 64'(acc_q_q);
        sum_i  = sat_add(base_i, prod_i, ACC_W);
        sum_q  = sat_add(base_q, prod_q, ACC_W);
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        if (clear) begin
            acc_i_d = '0;
            acc_q_d = '0;
        end else if (seed || add) begin
            acc_i_d = ACC_W'(sum_i);
            acc_q_d = ACC_W'(sum_q);
        end
    end

    // Accumulator registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
        end
    end

    assign acc_i = acc_i_q;
    assign acc_q = acc_q_q;

endmodule

// File: rtl/tracking_correlator.sv
// Multi-tap GNSS tracking correlator: epoch-aligned coherent integration
// over int_len code epochs with a single-entry dump register.
module tracking_correlator
    import gps_track_pkg::*;
#(
    parameter int unsigned N_TAPS = 3,
    parameter int unsigned IN_W   = 3,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned LEN_W  = 5
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic signed [IN_W-1:0]   data_in,
    input  logic [N_TAPS-1:0]        prn_taps,
    input  logic                     sin_sign,
    input  logic                     cos_sign,
    input  logic                     epoch,
    input  logic [LEN_W-1:0]         int_len,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [N_TAPS*ACC_W-1:0]  dump_i,
    output logic [N_TAPS*ACC_W-1:0]  dump_q,
    output logic                     overrun
);

    corr_state_e             state_q, state_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        eff_len;
    logic [1:0]              run_q;
    logic                    run;
    logic                    acc_clear, acc_seed, acc_add, close;
    logic [N_TAPS*ACC_W-1:0] acc_i_flat, acc_q_flat;
    logic [N_TAPS*ACC_W-1:0] dump_i_q, dump_q_q;
    logic                    dump_valid_q, overrun_q;

    // Reset release is pushed through two flops so the FSM stays idle for
    // two edges after RST falls; assertion still takes effect immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            run_q <= '0;
        end else begin
            run_q <= {run_q[0], 1'b1};
        end
    end
    assign run = run_q[1];

    // A zero integration length means a single epoch.
    assign eff_len = (int_len == '0) ? LEN_W'(1) : int_len;

    // Next-state, epoch counting and accumulator control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        acc_clear = 1'b0;
        acc_seed  = 1'b0;
        acc_add   = 1'b0;
        close     = 1'b0;
        if (!run || !enable) begin
            state_d   = StIdle;
            cnt_d     = '0;
            acc_clear = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    acc_clear = 1'b1;
                    state_d   = StArm;
                end
                StArm: begin
                    acc_clear = 1'b1;
                    if (epoch && sample_valid) begin
                        acc_clear = 1'b0;
                        acc_seed  = 1'b1;
                        len_d     = eff_len;
                        cnt_d     = '0;
                        state_d   = StIntegrate;
                    end
                end
                StIntegrate: begin
                    if (sample_valid) begin
                        if (epoch && (cnt_q == len_q - LEN_W'(1))) begin
                            // Closing epoch: its sample opens the next period.
                            close    = 1'b1;
                            acc_seed = 1'b1;
                            len_d    = eff_len;
                            cnt_d    = '0;
                        end else begin
                            acc_add = 1'b1;
                            if (epoch) begin
                                cnt_d = cnt_q + LEN_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d   = StIdle;
                    acc_clear = 1'b1;
                end
            endcase
        end
    end

    // FSM, counter and latched length registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= LEN_W'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // One accumulator lane per code tap.
    for (genvar k = 0; k < N_TAPS; k++) begin : g_lane
        corr_acc_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .CLK    (CLK),
            .RST    (RST),
            .clear  (acc_clear),
            .seed   (acc_seed),
            .add    (acc_add),
            .sample (data_in),
            .neg_i  (prn_taps[k] ^ sin_sign),
            .neg_q  (prn_taps[k] ^ cos_sign),
            .acc_i  (acc_i_flat[k*ACC_W +: ACC_W]),
            .acc_q  (acc_q_flat[k*ACC_W +: ACC_W])
        );
    end

    // Dump register: load at close, release on handshake, flag overwrites.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dump_i_q     <= '0;
            dump_q_q     <= '0;
            dump_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (close) begin
                dump_i_q     <= acc_i_flat;
                dump_q_q     <= acc_q_flat;
                dump_valid_q <= 1'b1;
                if (dump_valid_q && !dump_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (dump_valid_q && dump_ready) begin
                dump_valid_q <= 1'b0;
            end
        end
    end

    assign dump_valid = dump_valid_q;
    assign dump_i     = dump_i_q;
    assign dump_q     = dump_q_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_tracking_correlator.sv
// Directed bench for tracking_correlator: default build plus an 8-bit
// accumulator build sharing the same stimulus for saturation.
module tb_tracking_correlator;
    import gps_track_pkg::*;

    localparam int unsigned N_TAPS = 3;
    localparam int unsigned IN_W   = 3;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned ACC8   = 8;

    logic                      CLK = 1'b0;
    logic                      RST = 1'b1;
    logic                      enable = 1'b0;
    logic                      sample_valid = 1'b0;
    logic signed [IN_W-1:0]    data_in = '0;
    logic [N_TAPS-1:0]         prn_taps = '0;
    logic                      sin_sign = 1'b0;
    logic                      cos_sign = 1'b0;
    logic                      epoch = 1'b0;
    logic [LEN_W-1:0]          int_len = 5'd1;
    logic                      dump_ready = 1'b1;
    logic                      dump_valid, overrun;
    logic [N_TAPS*ACC_W-1:0]   dump_i, dump_q;
    logic                      dump_valid8, overrun8;
    logic [N_TAPS*ACC8-1:0]    dump_i8, dump_q8;

    int n_tot = 0;
    int n_bad = 0;
    int n_dv  = 0;
    int n0;

    always #5 CLK = ~CLK;

    tracking_correlator #(
        .N_TAPS (N_TAPS), .IN_W (IN_W), .ACC_W (ACC_W), .LEN_W (LEN_W)
    ) dut (
        .CLK (CLK), .RST (RST), .enable (enable), .sample_valid (sample_valid),
        .data_in (data_in), .prn_taps (prn_taps), .sin_sign (sin_sign),
        .cos_sign (cos_sign), .epoch (epoch), .int_len (int_len),
        .dump_valid (dump_valid), .dump_ready (dump_ready), .dump_i (dump_i),
        .dump_q (dump_q), .overrun (overrun)
    );

    tracking_correlator #(
        .N_TAPS (N_TAPS), .IN_W (IN_W), .ACC_W (ACC8), .LEN_W (LEN_W)
    ) dut8 (
        .CLK (CLK), .RST (RST), .enable (enable), .sample_valid (sample_valid),
        .data_in (data_in), .prn_taps (prn_taps), .sin_sign (sin_sign),
        .cos_sign (cos_sign), .epoch (epoch), .int_len (int_len),
        .dump_valid (dump_valid8), .dump_ready (dump_ready), .dump_i (dump_i8),
        .dump_q (dump_q8), .overrun (overrun8)
    );

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [63:0] di(input int k);
        logic signed [ACC_W-1:0] v;
        v = dump_i[k*ACC_W +: ACC_W];
        return 64'(v);
    endfunction

    function automatic logic signed [63:0] dq(input int k);
        logic signed [ACC_W-1:0] v;
        v = dump_q[k*ACC_W +: ACC_W];
        return 64'(v);
    endfunction

    function automatic logic signed [63:0] di8(input int k);
        logic signed [ACC8-1:0] v;
        v = dump_i8[k*ACC8 +: ACC8];
        return 64'(v);
    endfunction

    function automatic logic signed [63:0] dq8(input int k);
        logic signed [ACC8-1:0] v;
        v = dump_q8[k*ACC8 +: ACC8];
        return 64'(v);
    endfunction

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (dump_valid) n_dv++;
    endtask

    task automatic send(input logic ep);
        sample_valid = 1'b1;
        epoch        = ep;
        tick();
        sample_valid = 1'b0;
        epoch        = 1'b0;
    endtask

    task automatic run_epoch(input int n);
        send(1'b1);
        for (int i = 1; i < n; i++) send(1'b0);
    endtask

    // Drop enable for one cycle, then wait until the channel is armed.
    task automatic restart();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
    endtask

    initial begin
        // Reset values, before any clock edge.
        #1;
        chk("rst_dump_valid", 64'(dump_valid), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_dump_i_zero", 64'(dump_i == '0), 1);
        chk("rst_dump_q_zero", 64'(dump_q == '0), 1);
        #22 RST = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        enable = 1'b1;
        tick();

        // int_len=1, 5000 samples per epoch, all +1.
        data_in = 3'sd1;
        send(1'b1);
        for (int i = 1; i < 5000; i++) send(1'b0);
        chk("e1_no_early_dump", 64'(dump_valid), 0);
        send(1'b1);
        chk("e1_dump_valid", 64'(dump_valid), 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("e1_i%0d", k), di(k), 5000);
            chk($sformatf("e1_q%0d", k), dq(k), 5000);
        end
        send(1'b0);
        chk("e1_accept_clears", 64'(dump_valid), 0);
        for (int i = 2; i < 5000; i++) send(1'b0);
        send(1'b1);
        chk("e2_dump_valid", 64'(dump_valid), 1);
        chk("e2_i0", di(0), 5000);
        chk("e2_q2", dq(2), 5000);

        // int_len=4, tap0 inverted chip, data +2, 10 samples per epoch.
        restart();
        int_len  = 5'd4;
        prn_taps = 3'b001;
        data_in  = 3'sd2;
        n0 = n_dv;
        for (int e = 0; e < 4; e++) run_epoch(10);
        send(1'b1);
        chk("l4a_valid", 64'(dump_valid), 1);
        chk("l4a_i0", di(0), -80);
        chk("l4a_q0", dq(0), -80);
        chk("l4a_i1", di(1), 80);
        chk("l4a_q2", dq(2), 80);
        for (int i = 1; i < 10; i++) send(1'b0);
        for (int e = 5; e < 8; e++) run_epoch(10);
        send(1'b1);
        chk("l4b_i0", di(0), -80);
        chk("l4b_i2", di(2), 80);
        chk("l4_dump_count", 64'(n_dv - n0), 2);

        // int_len=0 acts as 1; carrier signs; invalid epoch ignored.
        restart();
        int_len  = 5'd0;
        prn_taps = 3'b010;
        data_in  = -3'sd3;
        sin_sign = 1'b1;
        cos_sign = 1'b0;
        send(1'b1);
        for (int i = 0; i < 3; i++) send(1'b0);
        epoch = 1'b1;
        tick();
        epoch = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0);
        send(1'b1);
        chk("sg_valid", 64'(dump_valid), 1);
        chk("sg_i0", di(0), 21);
        chk("sg_q0", dq(0), -21);
        chk("sg_i1", di(1), -21);
        chk("sg_q1", dq(1), 21);
        chk("sg_i2", di(2), 21);

        // Unaccepted dump overwritten -> overrun; dump survives enable drop.
        restart();
        int_len  = 5'd1;
        prn_taps = 3'b000;
        data_in  = 3'sd1;
        sin_sign = 1'b0;
        send(1'b1);
        send(1'b0);
        send(1'b0);
        dump_ready = 1'b0;
        send(1'b1);
        chk("ov_first_i0", di(0), 3);
        chk("ov_none_yet", 64'(overrun), 0);
        for (int i = 0; i < 4; i++) send(1'b0);
        tick();
        tick();
        chk("ov_held_i0", di(0), 3);
        chk("ov_held_valid", 64'(dump_valid), 1);
        send(1'b1);
        chk("ov_new_i0", di(0), 5);
        chk("ov_valid", 64'(dump_valid), 1);
        chk("ov_flag", 64'(overrun), 1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        chk("ov_keep_valid", 64'(dump_valid), 1);
        chk("ov_keep_q1", dq(1), 5);
        dump_ready = 1'b1;
        tick();
        chk("ov_accepted", 64'(dump_valid), 0);
        chk("ov_sticky", 64'(overrun), 1);

        // Saturation on the 8-bit build: 100 samples of +3.
        restart();
        prn_taps = 3'b010;
        data_in  = 3'sd3;
        send(1'b1);
        for (int i = 1; i < 100; i++) send(1'b0);
        send(1'b1);
        chk("sat_valid8", 64'(dump_valid8), 1);
        chk("sat_i0_8", di8(0), 127);
        chk("sat_q0_8", dq8(0), 127);
        chk("sat_i1_8", di8(1), -127);
        chk("sat_i2_8", di8(2), 127);
        chk("sat_i0_24", di(0), 300);

        // Asynchronous reset mid-integration.
        restart();
        int_len  = 5'd2;
        prn_taps = 3'b000;
        data_in  = 3'sd1;
        run_epoch(4);
        run_epoch(4);
        #2 RST = 1'b1;
        #1;
        chk("ar_valid", 64'(dump_valid), 0);
        chk("ar_overrun", 64'(overrun), 0);
        chk("ar_dump_i_zero", 64'(dump_i == '0), 1);
        chk("ar_dump_q8_zero", 64'(dump_q8 == '0), 1);
        #2 RST = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n0 = n_dv;
        run_epoch(4);
        run_epoch(4);
        chk("ar_no_dump", 64'(n_dv - n0), 0);
        send(1'b1);
        chk("ar_dump_valid", 64'(dump_valid), 1);
        chk("ar_i0", di(0), 8);

        // One-cycle enable drop mid-period forces a fresh period.
        int_len = 5'd1;
        for (int i = 0; i < 3; i++) send(1'b0);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        n0 = n_dv;
        send(1'b1);
        send(1'b0);
        send(1'b0);
        chk("en_no_dump", 64'(n_dv - n0), 0);
        send(1'b1);
        for (int i = 0; i < 4; i++) send(1'b0);
        send(1'b1);
        chk("en_dump_valid", 64'(dump_valid), 1);
        chk("en_i0", di(0), 5);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/tracking_correlator.md
TRACKING_CORRELATOR -- requirements
Module: tracking_correlator

Interface
REQ-001 Parameter N_TAPS, default 3, number of code taps (tap 0 = early, 1 = punctual, 2 = late; more for multipath/very-early/very-late).
REQ-002 Parameter IN_W, default 3, signed sample width.
REQ-003 Parameter ACC_W, default 24, signed accumulator width per I/Q per tap.
REQ-004 Parameter LEN_W, default 5, width of int_len.
REQ-005 CLK  in  1  single system clock, all logic rising-edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  channel enable; low forces IDLE.
REQ-008 sample_valid  in  1  data_in, prn_taps and carrier bits qualify this cycle.
REQ-009 data_in  in  IN_W  signed two's-complement IF sample.
REQ-010 prn_taps  in  N_TAPS  code chip per tap; 0 = +1, 1 = -1.
REQ-011 sin_sign, cos_sign  in  1 each  carrier sign bits; 0 = +1, 1 = -1.
REQ-012 epoch  in  1  single-cycle code-epoch (1 ms) pulse, coincident with a sample.
REQ-013 int_len  in  LEN_W  integration length in epochs; 0 treated as 1; sampled only at period start.
REQ-014 dump_valid  out  1  dump registers hold an unconsumed result.
REQ-015 dump_ready  in  1  consumer accepts dump.
REQ-016 dump_i, dump_q  out  N_TAPS*ACC_W  packed per-tap results, tap 0 in LSBs.
REQ-017 overrun  out  1  sticky: a dump was overwritten before acceptance.

Function
REQ-018 Per valid sample and tap k: I_k += data_in*chip_k*sin_sign, Q_k += data_in*chip_k*cos_sign (signs applied as negation).
REQ-019 Accumulators saturate at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)-1); no wrap-around.
REQ-020 FSM states: IDLE, ARM, INTEGRATE.
REQ-021 IDLE: accumulators held at 0, no accumulation; enable=1 -> ARM.
REQ-022 ARM: wait for epoch; on epoch&sample_valid -> INTEGRATE, load accumulators with that sample's products, latch int_len, epoch counter = 0.
REQ-023 INTEGRATE: each epoch increments counter; when counter reaches latched int_len-1 at an epoch, period closes.
REQ-024 At close: accumulator totals (excluding the closing-epoch sample) copy to dump_i/dump_q; closing-epoch sample's products seed the next period; int_len re-latched; counter = 0.
REQ-025 dump_valid asserts the cycle after the closing epoch (latency 1 clock).
REQ-026 Transfer occurs on dump_valid&dump_ready; dump_valid deasserts next cycle unless a new dump lands in that same cycle, in which case it stays high with new data.
REQ-027 dump_i/dump_q stable while dump_valid=1 and not accepted, except on overwrite.
REQ-028 New dump while dump_valid=1 and dump_ready=0: overwrite dump registers, keep dump_valid=1, set overrun.
REQ-029 enable deasserted in any state: next cycle IDLE, accumulators cleared, pending dump retained until accepted.
REQ-030 sample_valid=0 cycles neither accumulate nor count epochs; epoch without sample_valid is ignored.

Reset
REQ-031 RST asserts: state IDLE, accumulators 0, counter 0, dump_valid 0, dump_i/dump_q 0, overrun 0, immediately, regardless of clock.
REQ-032 Reset mid-integration discards partial sums; no dump produced.
REQ-033 Deassertion of RST is synchronised by the system reset scheme; first state change is no earlier than the second CLK edge after deassertion.

Structure
REQ-034 Package gps_track_pkg holds the FSM state enum, tap index constants (TAP_E/TAP_P/TAP_L) and the saturating-add limit function.
REQ-035 One sub-module corr_acc_lane (one tap's I/Q accumulate, seed, clear, saturate) instantiated N_TAPS times via generate.

Verification
REQ-036 N_TAPS=3, int_len=1, data_in=+1, all chips/carrier 0, 5000 samples per epoch -> each dump_i = dump_q = 5000 per tap, dump_valid one cycle after each epoch.
REQ-037 int_len=4, dump_ready=1, prn_taps[0]=1, others 0, data_in=+2 -> per 4 epochs tap0 I = -(2*samples), taps 1,2 positive, exactly one dump per 4 epochs.
REQ-038 ACC_W=8, data_in=+3 constant for 100 samples -> I = +127 saturated, no sign flip.
REQ-039 dump_ready=0 across two closes -> second result replaces first, dump_valid stays 1, overrun=1 until RST.
REQ-040 RST pulsed mid-INTEGRATE (asynchronous, between edges) -> all outputs 0 at once, next dump only after ARM epoch plus int_len epochs.
REQ-041 enable dropped for 1 cycle mid-period -> IDLE, ARM, no dump until a full fresh period completes.
